frame_peak_finder: RTL

- Streaming stage that consumes a fixed-length frame of unsigned samples and reports the frame maximum and the index of its first occurrence.
- Sits downstream of the unsigned greater-than comparator: instantiates compare_great_than (WIDTH = DATA_W) as its datapath and consumes o_gt to decide running-max updates.
- Feeds result consumers, e.g. threshold/peak logic, over a valid/ready handshake.

---
 rtl/frame_peak_finder.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/frame_peak_finder.sv
// frame_peak_finder: streaming per-frame maximum finder with first-occurrence index.
// Also contains compare_great_than, the unsigned strict greater-than datapath element.
// Optional build macro FRAME_PEAK_MIN_EN adds a symmetric minimum path (o_min, o_min_idx).

module compare_great_than #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_gt
);
    // unsigned strict a > b
    always_comb o_gt = (i_a > i_b);
endmodule

module frame_peak_finder #(
    parameter int DATA_W    = 16,
    parameter int FRAME_LEN = 64,
    localparam int IDX_W    = $clog2(FRAME_LEN)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_max,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_busy
`ifdef FRAME_PEAK_MIN_EN
    ,
    output logic [DATA_W-1:0] o_min,
    output logic [IDX_W-1:0]  o_min_idx
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic {
        ACCUM,
        HOLD
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  cnt;
    logic [DATA_W-1:0] run_max;
    logic [IDX_W-1:0]  run_idx;
    logic              gt_max;
    logic              accept;
    logic              last;

    compare_great_than #(
        .WIDTH(DATA_W)
    ) u_cmp_max (
        .i_a (i_data),
        .i_b (run_max),
        .o_gt(gt_max)
    );

    // state register
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= ACCUM;
        else       state <= state_nxt;
    end

    // next state and handshake outputs
    always_comb begin
        state_nxt = state;
        o_ready   = 1'b0;
        o_valid   = 1'b0;
        o_busy    = 1'b0;
        accept    = 1'b0;
        last      = (cnt == LAST_IDX);
        case (state)
            ACCUM: begin
                o_ready = 1'b1;
                o_busy  = (cnt != '0);
                accept  = i_valid;
                if (i_valid && last) state_nxt = HOLD;
            end
            HOLD: begin
                o_valid = 1'b1;
                if (i_ready) state_nxt = ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
    end

    // running max/index tracking, sample counter and frame commit
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt     <= '0;
            run_max <= '0;
            run_idx <= '0;
            o_max   <= '0;
            o_idx   <= '0;
        end else if (accept) begin
            if (cnt == '0) begin
                run_max <= i_data;
                run_idx <= '0;
            end else if (gt_max) begin
                run_max <= i_data;
                run_idx <= cnt;
            end
            if (last) begin
                // last sample can never be sample 0 (FRAME_LEN >= 2), so only the compare matters
                cnt   <= '0;
                o_max <= gt_max ? i_data : run_max;
                o_idx <= gt_max ? cnt    : run_idx;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef FRAME_PEAK_MIN_EN
    logic [DATA_W-1:0] run_min;
    logic [IDX_W-1:0]  run_min_idx;
    logic              lt_min;

    // operands swapped: running min > sample means a new minimum
    compare_great_than #(
        .WIDTH(DATA_W)
    ) u_cmp_min (
        .i_a (run_min),
        .i_b (i_data),
        .o_gt(lt_min)
    );

    // running min/index tracking and commit, mirrors the max path
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            run_min     <= '0;
            run_min_idx <= '0;
            o_min       <= '0;
            o_min_idx   <= '0;
        end else if (accept) begin
            if (cnt == '0) begin
                run_min     <= i_data;
                run_min_idx <= '0;
            end else if (lt_min) begin
                run_min     <= i_data;
                run_min_idx <= cnt;
            end
            if (last) begin
                o_min     <= lt_min ? i_data : run_min;
                o_min_idx <= lt_min ? cnt    : run_min_idx;
            end
        end
    end
`else
    // minimum path not built
`endif

endmodule
